cache_fill_ctrl: RTL and testbench



---
 rtl/cache_fill_ctrl.sv | 157 +++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_fill_ctrl
//
// Refills one cache block at a time for a split I/D cache from a multi-cycle
// main memory. A miss latches the block-aligned base address, issues one
// word read per cycle, and writes each returned word into the data array of
// the requesting side. The tag/valid strobe is raised together with the
// last data word. The D side has fixed priority over the I side.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   miss_i, addr_i        I-cache miss request and byte address
//   miss_d, addr_d        D-cache miss request and byte address
//   mem_en, mem_addr      read request / address to main memory
//   mem_valid, mem_data   one returned word per cycle, in request order
//   busy_i, busy_d        stall outputs to each cache side
//   data_wen_i/_d         data-array write strobes
//   tag_wen_i/_d          tag/valid write strobes (with the last word)
//   word_idx              word slot within the block being written
//   fill_data             word being written (memory data passed through)
//   fill_base             block-aligned address of the current fill
// ---------------------------------------------------------------------------
module cache_fill_ctrl #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  localparam int IW    = $clog2(WORDS),
  localparam int OFS   = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic              miss_d,
  input  logic [DATA_W-1:0] addr_d,
  output logic              mem_en,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy_i,
  output logic              busy_d,
  output logic              data_wen_i,
  output logic              data_wen_d,
  output logic              tag_wen_i,
  output logic              tag_wen_d,
  output logic [IW-1:0]     word_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic [DATA_W-1:0] fill_base
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL_I = 2'd1;
  localparam logic [1:0] FILL_D = 2'd2;

  localparam logic [IW:0]   IC_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0] RC_ONE  = IW'(1);
  localparam logic [IW-1:0] RC_LAST = IW'(WORDS - 1);

  // Clears the block-offset bits of a byte address.
  localparam logic [DATA_W-1:0] BLOCK_MASK = {{(DATA_W-OFS){1'b1}}, {OFS{1'b0}}};

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] base_reg,  base_next;
  logic [IW:0]       ic_reg,    ic_next;
  logic [IW-1:0]     rc_reg,    rc_next;

  logic              filling;
  logic              issuing;
  logic              word_in;
  logic              last_word;
  logic [DATA_W-1:0] issue_ofs;

  assign filling   = (state_reg != IDLE);
  // WORDS is a power of two, so ic < WORDS is simply "top bit clear".
  assign issuing   = filling && !ic_reg[IW];
  // mem_valid outside a fill (stray or late after reset) is ignored here.
  assign word_in   = filling && mem_valid;
  assign last_word = word_in && (rc_reg == RC_LAST);
  // Word-addressed memory behind a byte address: stride of 2 per word.
  assign issue_ofs = DATA_W'({ic_reg, 1'b0});

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    ic_next    = ic_reg;
    rc_next    = rc_reg;
    case (state_reg)
      IDLE: begin
        // D side wins a simultaneous miss; I is picked up from IDLE later.
        if (miss_d) begin
          state_next = FILL_D;
          base_next  = addr_d & BLOCK_MASK;
          ic_next    = '0;
          rc_next    = '0;
        end else if (miss_i) begin
          state_next = FILL_I;
          base_next  = addr_i & BLOCK_MASK;
          ic_next    = '0;
          rc_next    = '0;
        end
      end
      FILL_I, FILL_D: begin
        if (issuing) begin
          ic_next = ic_reg + IC_ONE;
        end
        // Completion is counted from returned words only; the miss lines
        // are not looked at once a fill has started.
        if (word_in) begin
          rc_next = rc_reg + RC_ONE;
          if (last_word) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      ic_reg    <= '0;
      rc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      ic_reg    <= ic_next;
      rc_reg    <= rc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_en     = issuing;
  assign mem_addr   = issuing ? (base_reg + issue_ofs) : '0;

  assign data_wen_i = mem_valid && (state_reg == FILL_I);
  assign data_wen_d = mem_valid && (state_reg == FILL_D);
  assign tag_wen_i  = data_wen_i && (rc_reg == RC_LAST);
  assign tag_wen_d  = data_wen_d && (rc_reg == RC_LAST);

  // The miss term drops in the tag cycle so the cache can proceed on the
  // very next edge, even though the state is still FILL_x during that cycle.
  assign busy_i     = (state_reg == FILL_I) || (miss_i && !tag_wen_i);
  assign busy_d     = (state_reg == FILL_D) || (miss_d && !tag_wen_d);

  assign word_idx   = rc_reg;
  assign fill_data  = mem_data;
  assign fill_base  = base_reg;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_ctrl
//
// Directed bench for cache_fill_ctrl. A transaction-level model of the fill
// (which side is being filled, its base, how many reads were issued and how
// many words came back) predicts every output each cycle; a simple in-order
// memory with configurable latency and gaps answers the reads. Scenario
// checks pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_cache_fill_ctrl;

  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int IW     = 3;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_i, miss_d;
  logic [DATA_W-1:0] addr_i, addr_d;
  logic              mem_en;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data;
  logic              busy_i, busy_d;
  logic              data_wen_i, data_wen_d, tag_wen_i, tag_wen_d;
  logic [IW-1:0]     word_idx;
  logic [DATA_W-1:0] fill_data, fill_base;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .miss_i(miss_i), .addr_i(addr_i), .miss_d(miss_d), .addr_d(addr_d),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .busy_i(busy_i), .busy_d(busy_d),
    .data_wen_i(data_wen_i), .data_wen_d(data_wen_d),
    .tag_wen_i(tag_wen_i), .tag_wen_d(tag_wen_d),
    .word_idx(word_idx), .fill_data(fill_data), .fill_base(fill_base)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input logic [DATA_W-1:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // ---------------- memory: in order, LAT cycles, optional gaps ------------
  logic [DATA_W-1:0] req_q[$];
  int                rdy_q[$];
  int                gap_tab[8] = '{0, 2, 1, 3, 0, 3, 2, 1};
  bit                irregular = 1'b0;
  int                gap_left  = 0;
  int                gap_k     = 0;
  int                stray_n   = 0;

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      req_q.push_back(mem_addr);
      rdy_q.push_back(cyc + LAT);
    end
  end

  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_valid = 1'b0;
      mem_data  = '0;
      if (stray_n > 0) begin
        stray_n--;
        mem_valid = 1'b1;
        mem_data  = 16'hDEAD;
      end else if (irregular && gap_left > 0) begin
        gap_left--;
      end else if (req_q.size() > 0 && rdy_q[0] <= cyc) begin
        mem_valid = 1'b1;
        mem_data  = word_of(req_q.pop_front());
        void'(rdy_q.pop_front());
        if (irregular) begin
          gap_left = gap_tab[gap_k % 8];
          gap_k++;
        end
      end
    end
  end

  // ---------------- transaction-level fill model ---------------------------
  int                m_side = 0;   // 0 none, 1 I, 2 D
  logic [DATA_W-1:0] m_base = '0;
  int                m_iss  = 0;
  int                m_rcv  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_side = 0; m_base = '0; m_iss = 0; m_rcv = 0;
    end else if (m_side == 0) begin
      if (miss_d) begin
        m_side = 2; m_base = addr_d & 16'hFFF0; m_iss = 0; m_rcv = 0;
      end else if (miss_i) begin
        m_side = 1; m_base = addr_i & 16'hFFF0; m_iss = 0; m_rcv = 0;
      end
    end else begin
      if (m_iss < WORDS) m_iss++;
      if (mem_valid) begin
        m_rcv++;
        if (m_rcv == WORDS) m_side = 0;
      end
    end
  end

  // ---------------- per-cycle comparison and event logs --------------------
  int                dw_cnt_i = 0, dw_cnt_d = 0, tag_cnt_i = 0, tag_cnt_d = 0;
  int                tag_at_i = 0, mv_cnt = 0, bi_low = 0;
  int                log_cyc[$];
  logic [DATA_W-1:0] log_addr[$];
  int                tag_cyc = 0;

  logic              e_en, e_dwi, e_dwd, e_tagi, e_tagd;
  logic [DATA_W-1:0] e_addr;

  always @(negedge clk) begin
    if (chk_on) begin
      e_en   = (m_side != 0) && (m_iss < WORDS);
      e_addr = e_en ? m_base + DATA_W'(2 * m_iss) : '0;
      e_dwi  = (m_side == 1) && mem_valid;
      e_dwd  = (m_side == 2) && mem_valid;
      e_tagi = e_dwi && (m_rcv == WORDS - 1);
      e_tagd = e_dwd && (m_rcv == WORDS - 1);
      chk("mem_en",     mem_en,     e_en);
      chk("mem_addr",   mem_addr,   e_addr);
      chk("data_wen_i", data_wen_i, e_dwi);
      chk("data_wen_d", data_wen_d, e_dwd);
      chk("tag_wen_i",  tag_wen_i,  e_tagi);
      chk("tag_wen_d",  tag_wen_d,  e_tagd);
      chk("busy_i",     busy_i,     (m_side == 1) || (miss_i && !e_tagi));
      chk("busy_d",     busy_d,     (m_side == 2) || (miss_d && !e_tagd));
      chk("word_idx",   word_idx,   m_rcv % WORDS);
      chk("fill_base",  fill_base,  m_base);
      chk("wen_excl",   data_wen_i & data_wen_d, 0);
      if (e_dwi || e_dwd)
        chk("fill_data", fill_data, word_of(m_base + DATA_W'(2 * m_rcv)));

      if (data_wen_i) dw_cnt_i++;
      if (data_wen_d) dw_cnt_d++;
      if (tag_wen_i) begin tag_cnt_i++; tag_at_i = dw_cnt_i; end
      if (tag_wen_d) begin tag_cnt_d++; tag_cyc = cyc; end
      if (mem_valid) mv_cnt++;
      if (!busy_i) bi_low++;
      if (mem_en) begin log_cyc.push_back(cyc); log_addr.push_back(mem_addr); end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    dw_cnt_i = 0; dw_cnt_d = 0; tag_cnt_i = 0; tag_cnt_d = 0;
    tag_at_i = 0; mv_cnt = 0; bi_low = 0; tag_cyc = 0;
    log_cyc.delete(); log_addr.delete();
  endtask

  // Returns at the negedge of the tag cycle of the given side.
  task automatic wait_tag(input int side, input int maxc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if ((side == 1 && tag_wen_i === 1'b1) || (side == 2 && tag_wen_d === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: tag_wen not seen within %0d cycles", name, maxc);
    end
  endtask

  // Returns at the negedge of the first read request (fill cycle 0).
  task automatic wait_first_en(input int maxc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: mem_en not seen within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios -------------------------------------
  initial begin
    rst = 1'b1; miss_i = 1'b0; miss_d = 1'b0; addr_i = '0; addr_d = '0;
    step();
    chk_on = 1'b1;
    // Reset state; busy follows miss only while in IDLE.
    miss_i = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_base", fill_base, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_busy_i_follows", busy_i, 1);
    chk("rst_busy_d", busy_d, 0);
    step();
    miss_i = 1'b0; rst = 1'b0;
    step();
    $display("reset: checked idle outputs");

    // 1: D miss alone, latency 4.
    clear_logs();
    miss_d = 1'b1; addr_d = 16'h1236;
    wait_tag(2, 40, "s1_tag");
    step();
    miss_d = 1'b0;
    @(negedge clk);
    chk("s1_idle_mem_en", mem_en, 0);
    chk("s1_idle_busy_d", busy_d, 0);
    chk("s1_issue_count", log_addr.size(), 8);
    for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
      chk("s1_issue_addr", log_addr[k], 16'h1230 + 16'(2 * k));
      chk("s1_issue_cycle", log_cyc[k] - log_cyc[0], k);
    end
    if (log_cyc.size() > 0) chk("s1_tag_fill_cycle", tag_cyc - log_cyc[0], 11);
    chk("s1_fill_base", fill_base, 16'h1230);
    chk("s1_dw_count", dw_cnt_d, 8);
    chk("s1_tag_count", tag_cnt_d, 1);
    $display("scenario D-alone: %0d words, tag in fill cycle %0d", dw_cnt_d,
             log_cyc.size() > 0 ? tag_cyc - log_cyc[0] : -1);

    // 2: simultaneous misses, D first, one IDLE cycle, then I.
    clear_logs();
    miss_i = 1'b1; addr_i = 16'h0040; miss_d = 1'b1; addr_d = 16'h8000;
    wait_tag(2, 40, "s2_tag_d");
    chk("s2_busy_i_held", bi_low, 0);
    chk("s2_first_addr", log_addr.size() > 0 ? log_addr[0] : 16'hFFFF, 16'h8000);
    step();
    miss_d = 1'b0;
    @(negedge clk);
    chk("s2_idle_mem_en", mem_en, 0);
    chk("s2_idle_busy_i", busy_i, 1);
    @(negedge clk);
    chk("s2_i_start_en", mem_en, 1);
    chk("s2_i_start_addr", mem_addr, 16'h0040);
    wait_tag(1, 40, "s2_tag_i");
    step();
    miss_i = 1'b0;
    chk("s2_dw_d", dw_cnt_d, 8);
    chk("s2_dw_i", dw_cnt_i, 8);
    $display("scenario simultaneous: D %0d words then I %0d words", dw_cnt_d, dw_cnt_i);

    // 3: irregular memory gaps.
    clear_logs();
    irregular = 1'b1;
    miss_i = 1'b1; addr_i = 16'h2468;
    wait_tag(1, 80, "s3_tag");
    step();
    miss_i = 1'b0;
    irregular = 1'b0;
    step();
    chk("s3_dw_count", dw_cnt_i, 8);
    chk("s3_tag_count", tag_cnt_i, 1);
    chk("s3_tag_on_8th", tag_at_i, 8);
    chk("s3_base", fill_base, 16'h2460);
    $display("scenario irregular: %0d words, tag with word %0d", dw_cnt_i, tag_at_i);

    // 4: reset during fill cycle 6.
    clear_logs();
    miss_d = 1'b1; addr_d = 16'h0A0C;
    wait_first_en(10, "s4_start");
    repeat (6) step();
    rst = 1'b1; miss_d = 1'b0;
    step();
    rst = 1'b0;
    chk("s4_dw_before_rst", dw_cnt_d, 3);
    chk("s4_no_tag", tag_cnt_d, 0);
    clear_logs();
    for (int k = 0; k < 20 && req_q.size() > 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("s4_late_pulses", mv_cnt, 4);
    chk("s4_late_dw", dw_cnt_d + dw_cnt_i, 0);
    chk("s4_late_tag", tag_cnt_d + tag_cnt_i, 0);
    chk("s4_idle_mem_en", mem_en, 0);
    $display("scenario reset-mid-fill: %0d late pulses ignored", mv_cnt);

    // 5: miss_i dropped in fill cycle 2.
    step();
    clear_logs();
    miss_i = 1'b1; addr_i = 16'h0100;
    wait_first_en(10, "s5_start");
    repeat (2) step();
    miss_i = 1'b0;
    wait_tag(1, 40, "s5_tag");
    step();
    chk("s5_dw_count", dw_cnt_i, 8);
    chk("s5_tag_count", tag_cnt_i, 1);
    $display("scenario miss-dropped: %0d words, %0d tag", dw_cnt_i, tag_cnt_i);

    // 6: stray mem_valid in IDLE after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_logs();
    stray_n = 3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("s6_mem_en", mem_en, 0);
      chk("s6_mem_addr", mem_addr, 0);
      chk("s6_strobes", {data_wen_i, data_wen_d, tag_wen_i, tag_wen_d}, 0);
      chk("s6_word_idx", word_idx, 0);
      chk("s6_fill_base", fill_base, 0);
      chk("s6_busy", {busy_i, busy_d}, 0);
    end
    chk("s6_stray_seen", mv_cnt, 3);
    $display("scenario stray-valid: %0d pulses, outputs idle", mv_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
